// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, state encoding and width helper for the I2S/LJ receiver
package i2s_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } i2s_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2s_slot_shifter.sv
// rtl/i2s_slot_shifter.sv - MSB-first sample shift register with captured-bit counter
module i2s_slot_shifter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   clear,
  input  logic                   data_in,
  output logic [SAMPLE_BITS-1:0] sample,
  output logic                   done
);

  localparam int CW = cnt_width(SAMPLE_BITS);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_BITS);

  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  // sample/done describe the word as it would be with this cycle's bit appended,
  // so the caller can consume a completing slot even while clear restarts it.
  assign sample = {shift_q[SAMPLE_BITS-2:0], data_in};
  assign done   = (cnt_q == LAST);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
      if (shift_en) begin
        shift_d = {{(SAMPLE_BITS-1){1'b0}}, data_in};
        cnt_d   = CW'(1);
      end
    end else if (shift_en && cnt_q != FULL) begin
      shift_d = sample;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/i2s_rx_pcm.sv
// rtl/i2s_rx_pcm.sv - I2S/left-justified serial to stereo PCM receiver; I2S_RX_FRAME_ERR_EN enables frame_err
module i2s_rx_pcm
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = 8,
  parameter int SLOT_BITS   = 16,
  parameter int MODE        = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ws,
  input  logic                   data_in,
  output logic [SAMPLE_BITS-1:0] left_out,
  output logic [SAMPLE_BITS-1:0] right_out,
  output logic                   sample_valid,
  output logic                   frame_err
);

  localparam int SW = cnt_width(SLOT_BITS);
  localparam logic [SW-1:0] SLOT_END = SW'(SLOT_BITS);
  localparam bit LJ = (MODE == MODE_LJ);

  i2s_state_e             state_q, state_d, phase;
  logic [SW-1:0]          slot_cnt_q, slot_cnt_d;
  logic                   prev_ws_q, prev_ws_d;
  logic                   channel_q, channel_d;
  logic                   staged_vld_q, staged_vld_d;
  logic [SAMPLE_BITS-1:0] staged_q, staged_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d, right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   ws_edge, slot_done, sh_done;
  logic [SAMPLE_BITS-1:0] sh_sample;

  assign ws_edge   = (ws != prev_ws_q);
  assign slot_done = (state_q == ST_SHIFT) && sh_done;

  // The edge cycle is the I2S one-bit delay, so DELAY is only ever the role of
  // that cycle; the registered state moves straight on to SHIFT.
  assign phase = ws_edge ? (LJ ? ST_SHIFT : ST_DELAY) : state_q;

  i2s_slot_shifter #(.SAMPLE_BITS(SAMPLE_BITS)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .shift_en (phase == ST_SHIFT),
    .clear    (ws_edge),
    .data_in  (data_in),
    .sample   (sh_sample),
    .done     (sh_done)
  );

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    channel_d  = channel_q;
    prev_ws_d  = ws;
    if (ws_edge) begin
      state_d    = ST_SHIFT;
      slot_cnt_d = SW'(1);
      channel_d  = ws;
    end else if (state_q != ST_IDLE) begin
      if (slot_cnt_q == SLOT_END) begin
        state_d    = ST_IDLE;
        slot_cnt_d = '0;
      end else begin
        slot_cnt_d = slot_cnt_q + SW'(1);
        if (slot_done) state_d = ST_PAD;
      end
    end
  end

  // A right sample is only published when a left one is waiting, keeping pairs atomic.
  always_comb begin
    staged_d     = staged_q;
    staged_vld_d = staged_vld_q;
    left_d       = left_q;
    right_d      = right_q;
    valid_d      = 1'b0;
    if (slot_done) begin
      if (!channel_q) begin
        staged_d     = sh_sample;
        staged_vld_d = 1'b1;
      end else if (staged_vld_q) begin
        left_d       = staged_q;
        right_d      = sh_sample;
        valid_d      = 1'b1;
        staged_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      slot_cnt_q   <= '0;
      prev_ws_q    <= ws;
      channel_q    <= 1'b0;
      staged_vld_q <= 1'b0;
      staged_q     <= '0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      prev_ws_q    <= prev_ws_d;
      channel_q    <= channel_d;
      staged_vld_q <= staged_vld_d;
      staged_q     <= staged_d;
      left_q       <= left_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
    end
  end

  assign left_out     = left_q;
  assign right_out    = right_q;
  assign sample_valid = valid_q;

`ifdef I2S_RX_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  always_comb begin
    frame_err_d = (ws_edge && state_q == ST_SHIFT && !sh_done) ||
                  (!ws_edge && state_q != ST_IDLE && slot_cnt_q == SLOT_END);
  end

  always_ff @(posedge clk) begin
    if (reset) frame_err_q <= 1'b0;
    else       frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule
